// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
//
// Purpose:
//   Runs one radix-2 step per cycle (shift-add multiply, restoring divide)
//   on unsigned magnitudes, then applies sign correction in a final FIXUP
//   cycle that writes HI/LO. MTHI/MTLO write HI/LO directly from IDLE.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-high reset
//   start   in   one-cycle request from the execute stage
//   md_op   in   0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6/7=no-op
//   rs_val  in   operand A (multiplicand / dividend / MTHI-MTLO source)
//   rt_val  in   operand B (multiplier / divisor)
//   flush   in   squash the in-flight operation
//   busy    out  high while an operation is in flight
//   done    out  high in the cycle whose closing edge writes the result
//   hi      out  HI register
//   lo      out  LO register

module ex_muldiv_unit #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  HILO_RST = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      md_op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2
    } state_t;

    state_t            state_q,  state_d;
    logic [CW-1:0]     cnt_q,    cnt_d;
    // acc_hi/acc_lo: product high/low for multiply, remainder/quotient for divide
    logic [XLEN-1:0]   acc_hi_q, acc_hi_d;
    logic [XLEN-1:0]   acc_lo_q, acc_lo_d;
    // opnd holds |A| (multiplicand) for multiply, |B| (divisor) for divide
    logic [XLEN-1:0]   opnd_q,   opnd_d;
    logic              is_div_q, is_div_d;
    logic              neg_q,    neg_d;
    logic              rneg_q,   rneg_d;
    logic [XLEN-1:0]   hi_q,     hi_d;
    logic [XLEN-1:0]   lo_q,     lo_d;

    logic              op_signed;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_neg;

    always_comb begin
        op_signed = (md_op == OP_MULT) || (md_op == OP_DIV);
        a_neg     = op_signed && rs_val[XLEN-1];
        b_neg     = op_signed && rt_val[XLEN-1];
        // Magnitude of the most negative value wraps to itself, which is the
        // correct unsigned magnitude.
        abs_a     = a_neg ? -rs_val : rs_val;
        abs_b     = b_neg ? -rt_val : rt_val;
    end

    // Datapath for one iteration step and for the final sign correction.
    always_comb begin
        // Multiply: add multiplicand when the current multiplier bit is set,
        // then shift the whole accumulator right by one.
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        // Divide: shift remainder:quotient left, trial-subtract divisor.
        div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        prod      = {acc_hi_q, acc_lo_q};
        prod_neg  = -prod;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    case (md_op)
                        OP_MULT, OP_MULTU: begin
                            acc_hi_d = '0;
                            acc_lo_d = abs_b;
                            opnd_d   = abs_a;
                            is_div_d = 1'b0;
                            neg_d    = a_neg ^ b_neg;
                            rneg_d   = 1'b0;
                            cnt_d    = '0;
                            state_d  = S_CALC;
                        end
                        OP_DIV, OP_DIVU: begin
                            is_div_d = 1'b1;
                            cnt_d    = '0;
                            if (rt_val == '0) begin
                                // No trap: result is preloaded uncorrected and
                                // the iteration is skipped entirely.
                                acc_hi_d = rs_val;
                                acc_lo_d = '1;
                                opnd_d   = '0;
                                neg_d    = 1'b0;
                                rneg_d   = 1'b0;
                                state_d  = S_FIXUP;
                            end else begin
                                acc_hi_d = '0;
                                acc_lo_d = abs_a;
                                opnd_d   = abs_b;
                                neg_d    = a_neg ^ b_neg;
                                rneg_d   = a_neg;
                                state_d  = S_CALC;
                            end
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end

            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        if (!div_diff[XLEN]) begin
                            acc_hi_d = div_diff[XLEN-1:0];
                            acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            acc_hi_d = div_shift[XLEN-1:0];
                            acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi_d = mul_sum[XLEN:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIXUP;
                    end
                end
            end

            S_FIXUP: begin
                state_d = S_IDLE;
                // A flush here wins over the architectural write.
                if (!flush) begin
                    if (is_div_q) begin
                        hi_d = rneg_q ? -acc_hi_q : acc_hi_q;
                        lo_d = neg_q  ? -acc_lo_q : acc_lo_q;
                    end else if (neg_q) begin
                        hi_d = prod_neg[2*XLEN-1:XLEN];
                        lo_d = prod_neg[XLEN-1:0];
                    end else begin
                        hi_d = acc_hi_q;
                        lo_d = acc_lo_q;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            hi_q     <= HILO_RST;
            lo_q     <= HILO_RST;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // busy is a pure state decode, so it is 0 in the cycle that accepts start.
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_FIXUP) && !flush;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
